or1200_vlx_pack: RTL and testbench

Parametrised variable-length-code packer for the OR1200 JPEG path, the successor to the fixed 32-bit VLX store unit. It accepts left-to-right bit fields of 0..31 bits from the `set_bit` custom instruction into a wide accumulator and extracts whole bytes into a byte FIFO. It applies JPEG 0xFF/0x00 byte stuffing when enabled and writes the bytes to memory through a single-byte bus handshake at an auto-incrementing address. It generates its own CPU stall for backpressure, flush and unsafe SPR writes.

---
 rtl/or1200_vlx_pack.sv | 232 +++++++++++++++++++++++
 tb/tb_or1200_vlx_pack.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/or1200_vlx_pack.sv
// Variable-length-code packer: bit fields are appended into an accumulator, bytes go to a FIFO, and the FIFO drains to a byte bus.
// Latency: an op that completes a byte is pushed at edge 1, and store_byte_o rises at edge 2. Sustains 1 byte/cycle with continuous ack.
// Backpressure: stall_cpu_o when the accumulator lacks room, while flushing, or on an address write while busy.

// Generic byte FIFO. Push and pop in the same cycle are legal even when full.
module or1200_vlx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign level    = wr_ptr - rd_ptr;
  assign empty    = (level == '0);
  assign full     = (level == (AW+1)'(DEPTH));
  assign head_dat = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; the contents need no reset because the pointers qualify them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

module or1200_vlx_pack #(
  parameter int ACC_W      = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int STUFF_EN   = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        set_bit_op_i,
  input  logic [31:0] bits_i,
  input  logic [4:0]  len_i,
  input  logic        spr_cs_i,
  input  logic        spr_write_i,
  input  logic [1:0]  spr_addr_i,
  input  logic [31:0] spr_dat_i,
  output logic [31:0] spr_dat_o,
  output logic        stall_cpu_o,
  output logic        store_byte_o,
  output logic [31:0] vlx_addr_o,
  output logic [31:0] dat_o,
  input  logic        ack_i
);
  localparam int CW = $clog2(ACC_W + 1);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic { EXTRACT, STUFF } ext_state_t;
  typedef enum logic { IDLE, REQ }      bus_state_t;

  // Valid bits sit right-aligned in acc[cnt-1:0]; the oldest bit is the highest valid one.
  logic [ACC_W-1:0] acc;
  logic [CW-1:0]    cnt;
  ext_state_t       ext_state;
  bus_state_t       bus_state;
  logic [31:0]      addr;
  logic             flushing;

  // FIFO interface
  logic             fifo_push;
  logic [7:0]       fifo_push_dat;
  logic             fifo_pop;
  logic [7:0]       fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LW-1:0]    fifo_level;

  // Datapath controls
  logic [CW-1:0]    free_bits;
  logic             room;
  logic             accept;
  logic             fifo_space;
  logic             extract_push;
  logic             stuff_push;
  logic [7:0]       top_byte;
  logic [31:0]      field_mask;
  logic [3:0]       pad_len;
  logic [7:0]       pad_ones;
  logic             pad;
  logic [CW-1:0]    cnt_next;
  logic             busy_core;
  logic             busy;
  logic             flush_wr;
  logic             addr_wr_req;
  logic             addr_wr;

  or1200_vlx_fifo #(
    .W     (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .push     (fifo_push),
    .push_dat (fifo_push_dat),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign free_bits  = CW'(ACC_W) - cnt;
  assign room       = (free_bits >= CW'(len_i));
  // A stalled op is held by the CPU, so it must not be taken while flushing or it would be appended twice.
  assign accept     = set_bit_op_i & room & ~flushing;
  assign field_mask = (32'h1 << len_i) - 32'h1;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a byte.
  assign fifo_pop     = (bus_state == REQ) & ack_i;
  assign fifo_space   = ~fifo_full | fifo_pop;
  assign top_byte     = 8'(acc >> (cnt - CW'(8)));
  assign extract_push = (ext_state == EXTRACT) & (cnt >= CW'(8)) & fifo_space;
  assign stuff_push   = (ext_state == STUFF) & fifo_space;
  assign fifo_push    = extract_push | stuff_push;
  assign fifo_push_dat = stuff_push ? 8'h00 : top_byte;

  // Flush padding fills with 1s up to the next byte boundary, and only when the padded bits fit.
  assign pad_len  = 4'd8 - {1'b0, cnt[2:0]};
  assign pad_ones = 8'hFF >> cnt[2:0];
  assign pad      = flushing & (cnt[2:0] != 3'd0) & (free_bits >= CW'(pad_len));

  // Bit count after this cycle's append, pad and extraction; accept and pad never coincide.
  always_comb begin
    cnt_next = cnt;
    if (accept)       cnt_next = cnt_next + CW'(len_i);
    if (pad)          cnt_next = cnt_next + CW'(pad_len);
    if (extract_push) cnt_next = cnt_next - CW'(8);
  end

  // Accumulator and the extract/stuff FSM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc       <= '0;
      cnt       <= '0;
      ext_state <= EXTRACT;
    end else begin
      cnt <= cnt_next;
      if (accept)
        acc <= (acc << len_i) | ACC_W'(bits_i & field_mask);
      else if (pad)
        acc <= (acc << pad_len) | ACC_W'(pad_ones);
      case (ext_state)
        EXTRACT: if (extract_push && (STUFF_EN != 0) && (top_byte == 8'hFF)) ext_state <= STUFF;
        STUFF:   if (fifo_space) ext_state <= EXTRACT;
        default: ext_state <= EXTRACT;
      endcase
    end
  end

  assign busy_core   = (cnt != '0) | ~fifo_empty | (bus_state == REQ) | (ext_state == STUFF);
  assign busy        = busy_core | flushing;
  assign flush_wr    = spr_cs_i & spr_write_i & (spr_addr_i == 2'd1) & spr_dat_i[0];
  assign addr_wr_req = spr_cs_i & spr_write_i & (spr_addr_i == 2'd2);
  assign stall_cpu_o = (set_bit_op_i & ~room) | flushing | (addr_wr_req & busy);
  // Moving the address under in-flight bytes would split the stream, so the write waits for idle.
  assign addr_wr     = addr_wr_req & ~stall_cpu_o;

  // Bus request FSM with a registered request strobe and the auto-incrementing address.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus_state    <= IDLE;
      store_byte_o <= 1'b0;
      addr         <= '0;
    end else begin
      if (addr_wr)       addr <= spr_dat_i;
      else if (fifo_pop) addr <= addr + 32'd1;
      case (bus_state)
        IDLE: begin
          if (!fifo_empty) begin
            bus_state    <= REQ;
            store_byte_o <= 1'b1;
          end
        end
        REQ: begin
          if (ack_i && !((fifo_level > LW'(1)) || fifo_push)) begin
            bus_state    <= IDLE;
            store_byte_o <= 1'b0;
          end
        end
        default: begin
          bus_state    <= IDLE;
          store_byte_o <= 1'b0;
        end
      endcase
    end
  end

  // Flush stays set until every buffered bit has left the block; repeat writes are ignored.
  always_ff @(posedge clk_i) begin
    if (rst_i)         flushing <= 1'b0;
    else if (flushing) flushing <= busy_core;
    else if (flush_wr) flushing <= 1'b1;
  end

  assign vlx_addr_o = addr;
  assign dat_o      = store_byte_o ? {4{fifo_head}} : 32'h0;

  // SPR read mux.
  always_comb begin
    spr_dat_o = 32'h0;
    case (spr_addr_i)
      2'd0:    spr_dat_o = {busy, 7'b0, 8'(fifo_level), 8'b0, 8'(cnt)};
      2'd1:    spr_dat_o = {31'b0, flushing};
      2'd2:    spr_dat_o = addr;
      default: spr_dat_o = 32'h0;
    endcase
  end
endmodule

// File: tb/tb_or1200_vlx_pack.sv
module tb_or1200_vlx_pack;
  localparam int STUFF = 1;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        set_bit_op_i;
  logic [31:0] bits_i;
  logic [4:0]  len_i;
  logic        spr_cs_i;
  logic        spr_write_i;
  logic [1:0]  spr_addr_i;
  logic [31:0] spr_dat_i;
  logic [31:0] spr_dat_o;
  logic        stall_cpu_o;
  logic        store_byte_o;
  logic [31:0] vlx_addr_o;
  logic [31:0] dat_o;
  logic        ack_i = 1'b0;

  int errors = 0;
  int checks = 0;
  int ack_mode = 0;  // 0 = never ack, 1 = always ack, 2 = random ack

  // Reference model: a bit queue, plus expected {addr, byte} and observed {addr, dat} streams.
  bit          mbits[$];
  logic [39:0] exp_q[$];
  logic [63:0] obs_q[$];
  logic [31:0] maddr = 32'h0;

  always #5 clk = ~clk;

  or1200_vlx_pack #(.ACC_W(64), .FIFO_DEPTH(8), .STUFF_EN(STUFF)) dut (
    .clk_i(clk), .rst_i(rst_i), .set_bit_op_i(set_bit_op_i), .bits_i(bits_i), .len_i(len_i),
    .spr_cs_i(spr_cs_i), .spr_write_i(spr_write_i), .spr_addr_i(spr_addr_i), .spr_dat_i(spr_dat_i),
    .spr_dat_o(spr_dat_o), .stall_cpu_o(stall_cpu_o), .store_byte_o(store_byte_o),
    .vlx_addr_o(vlx_addr_o), .dat_o(dat_o), .ack_i(ack_i)
  );

  initial forever begin
    @(posedge clk); #1;
    if (ack_mode == 1)      ack_i = 1'b1;
    else if (ack_mode == 2) ack_i = 1'($urandom_range(0, 1));
    else                    ack_i = 1'b0;
  end

  // Each completed handshake is recorded in the cycle before the completing edge.
  always @(negedge clk) begin
    if (!rst_i && store_byte_o && ack_i) obs_q.push_back({vlx_addr_o, dat_o});
  end

  function automatic void model_emit();
    logic [7:0] b;
    while (mbits.size() >= 8) begin
      b = 8'h0;
      for (int i = 0; i < 8; i++) b = {b[6:0], mbits.pop_front()};
      exp_q.push_back({maddr, b});
      maddr = maddr + 32'd1;
      if (STUFF != 0 && b == 8'hFF) begin
        exp_q.push_back({maddr, 8'h00});
        maddr = maddr + 32'd1;
      end
    end
  endfunction

  function automatic void model_push(input logic [31:0] b, input int l);
    for (int i = l - 1; i >= 0; i--) mbits.push_back(b[i]);
    model_emit();
  endfunction

  function automatic void model_flush();
    while (mbits.size() % 8 != 0) mbits.push_back(1'b1);
    model_emit();
  endfunction

  task automatic do_op(input logic [31:0] b, input int l);
    int t = 0;
    @(negedge clk);
    set_bit_op_i = 1'b1; bits_i = b; len_i = l[4:0];
    #1;
    while (stall_cpu_o && t < 2000) begin @(negedge clk); #1; t++; end
    if (t >= 2000) begin
      checks++; errors++;
      $display("FAIL op_accept_timeout: op %h/%0d still stalled after %0d cycles", b, l, t);
    end else model_push(b, l);
    @(posedge clk); #1;
    set_bit_op_i = 1'b0;
  endtask

  task automatic spr_wr(input logic [1:0] a, input logic [31:0] d);
    int t = 0;
    @(negedge clk);
    spr_cs_i = 1'b1; spr_write_i = 1'b1; spr_addr_i = a; spr_dat_i = d;
    #1;
    while (stall_cpu_o && t < 2000) begin @(negedge clk); #1; t++; end
    if (t >= 2000) begin
      checks++; errors++;
      $display("FAIL spr_write_timeout: addr %0d still stalled", a);
    end
    @(posedge clk); #1;
    spr_cs_i = 1'b0; spr_write_i = 1'b0;
  endtask

  task automatic spr_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    spr_cs_i = 1'b1; spr_write_i = 1'b0; spr_addr_i = a;
    #1;
    d = spr_dat_o;
    spr_cs_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((obs_q.size() < exp_q.size() || store_byte_o || stall_cpu_o) && t < 3000) begin
      @(negedge clk); t++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (t >= 3000) begin
      errors++;
      $display("FAIL %s_drain: stored %0d bytes, required %0d", name, obs_q.size(), exp_q.size());
    end
  endtask

  task automatic compare_stream(input string name);
    logic [39:0] e;
    int n;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: stored %0d bytes, required %0d", name, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q[i];
      checks++;
      if (obs_q[i] !== {e[39:8], {4{e[7:0]}}}) begin
        errors++;
        $display("FAIL %s_byte%0d: got addr %h dat %h, required addr %h dat %h",
                 name, i, obs_q[i][63:32], obs_q[i][31:0], e[39:8], {4{e[7:0]}});
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({store_byte_o, vlx_addr_o, dat_o, stall_cpu_o} !== 66'h0) begin
      errors++;
      $display("FAIL reset_outputs: store=%b addr=%h dat=%h stall=%b, required all zero",
               store_byte_o, vlx_addr_o, dat_o, stall_cpu_o);
    end
    @(negedge clk); rst_i = 1'b0;
    for (int a = 0; a < 4; a++) begin
      spr_rd(a[1:0], d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_spr%0d: got %h required 0", a, d); end
    end
  endtask

  task automatic test_sequential();
    logic [31:0] d;
    ack_mode = 1;
    spr_wr(2'd2, 32'h1000); maddr = 32'h1000;
    do_op(32'hAB, 8);
    checks++;
    if (store_byte_o !== 1'b0) begin errors++; $display("FAIL lat_edge0: store=%b required 0", store_byte_o); end
    @(posedge clk); #1;
    checks++;
    if (store_byte_o !== 1'b0) begin errors++; $display("FAIL lat_edge1: store=%b required 0", store_byte_o); end
    @(posedge clk); #1;
    checks++;
    if ({store_byte_o, vlx_addr_o, dat_o} !== {1'b1, 32'h1000, 32'hABABABAB}) begin
      errors++;
      $display("FAIL lat_edge2: store=%b addr=%h dat=%h required 1/00001000/abababab", store_byte_o, vlx_addr_o, dat_o);
    end
    do_op(32'hCD, 8);
    wait_drain("seq");
    compare_stream("seq");
    spr_rd(2'd2, d);
    checks++;
    if (d !== 32'h1002) begin errors++; $display("FAIL seq_addr: got %h required 00001002", d); end
  endtask

  task automatic test_stuffing();
    ack_mode = 1;
    spr_wr(2'd2, 32'h1000); maddr = 32'h1000;
    do_op(32'hFF, 8);
    wait_drain("stuff");
    checks++;
    if (obs_q.size() != 2 || obs_q[1][7:0] !== 8'h00) begin
      errors++;
      $display("FAIL stuff_zero: stored %0d bytes, required FF then 00", obs_q.size());
    end
    compare_stream("stuff");
  endtask

  task automatic test_flush_pad();
    logic [31:0] d;
    int t = 0;
    ack_mode = 1;
    spr_wr(2'd2, 32'h1000); maddr = 32'h1000;
    do_op(32'b101, 3);
    do_op(32'b11, 2);
    spr_wr(2'd1, 32'h1);
    model_flush();
    checks++;
    if (stall_cpu_o !== 1'b1) begin errors++; $display("FAIL flush_stall: got %b required 1", stall_cpu_o); end
    spr_rd(2'd1, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL flush_ctrl: got %h required 1", d); end
    while (stall_cpu_o && t < 200) begin @(negedge clk); #1; t++; end
    checks++;
    if (t >= 200 || obs_q.size() != 1) begin
      errors++;
      $display("FAIL flush_stall_release: stall fell after %0d cycles with %0d bytes stored, required 1", t, obs_q.size());
    end
    wait_drain("flush");
    checks++;
    if (obs_q.size() < 1 || obs_q[0][7:0] !== 8'hBF) begin
      errors++;
      $display("FAIL flush_byte: got %0d bytes, first %h, required BF", obs_q.size(), obs_q.size() ? obs_q[0][7:0] : 8'h0);
    end
    compare_stream("flush");
    spr_rd(2'd0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL flush_status: got %h required 0", d); end
  endtask

  task automatic test_flush_idle();
    spr_wr(2'd1, 32'h1);
    checks++;
    if (stall_cpu_o !== 1'b1) begin errors++; $display("FAIL idle_flush_c1: stall %b required 1", stall_cpu_o); end
    @(posedge clk); #1;
    checks++;
    if (stall_cpu_o !== 1'b0) begin errors++; $display("FAIL idle_flush_c2: stall %b required 0", stall_cpu_o); end
  endtask

  task automatic test_addr_write_busy();
    logic [31:0] d;
    int t = 0;
    ack_mode = 0;
    do_op(32'h1234, 16);
    repeat (4) @(negedge clk);
    spr_cs_i = 1'b1; spr_write_i = 1'b1; spr_addr_i = 2'd2; spr_dat_i = 32'h2000;
    #1;
    checks++;
    if (stall_cpu_o !== 1'b1) begin errors++; $display("FAIL addrwr_stall: got %b required 1", stall_cpu_o); end
    ack_mode = 1;
    while (stall_cpu_o && t < 200) begin @(negedge clk); #1; t++; end
    checks++;
    if (t >= 200) begin errors++; $display("FAIL addrwr_release: stall held %0d cycles", t); end
    @(posedge clk); #1;
    spr_cs_i = 1'b0; spr_write_i = 1'b0;
    wait_drain("addrwr");
    compare_stream("addrwr");
    maddr = 32'h2000;
    spr_rd(2'd2, d);
    checks++;
    if (d !== 32'h2000) begin errors++; $display("FAIL addrwr_value: got %h required 00002000", d); end
    do_op(32'h55, 8);
    wait_drain("addrwr2");
    compare_stream("addrwr2");
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    int hi = 0;
    int t = 0;
    ack_mode = 0;
    @(negedge clk);
    set_bit_op_i = 1'b1; bits_i = 32'h7FFFFFFF; len_i = 5'd31;
    while (hi < 20 && t < 400) begin
      #1;
      if (stall_cpu_o) hi++;
      else begin hi = 0; model_push(32'h7FFFFFFF, 31); end
      @(negedge clk); t++;
    end
    checks++;
    if (hi < 20) begin errors++; $display("FAIL bp_stall: stall never held, %0d cycles", t); end
    spr_rd(2'd0, d);
    checks++;
    if (d[31] !== 1'b1 || d[23:16] !== 8'd8 || d[7:0] < 8'd34 || d[7:0] > 8'd64) begin
      errors++;
      $display("FAIL bp_status: busy=%b level=%0d cnt=%0d, required busy 1, level 8, cnt 34..64", d[31], d[23:16], d[7:0]);
    end
    ack_mode = 2;
    t = 0;
    #1;
    while (stall_cpu_o && t < 500) begin @(negedge clk); #1; t++; end
    checks++;
    if (t >= 500) begin errors++; $display("FAIL bp_resume: op still stalled"); end
    else model_push(32'h7FFFFFFF, 31);
    @(posedge clk); #1;
    set_bit_op_i = 1'b0;
    spr_wr(2'd1, 32'h1);
    model_flush();
    wait_drain("bp");
    compare_stream("bp");
  endtask

  task automatic test_random();
    logic [31:0] b;
    logic [31:0] d;
    int l;
    ack_mode = 2;
    spr_wr(2'd2, 32'hFFFF_FFF0); maddr = 32'hFFFF_FFF0;
    for (int i = 0; i < 60; i++) begin
      l = $urandom_range(0, 31);
      b = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      do_op(b, l);
    end
    spr_wr(2'd1, 32'h1);
    model_flush();
    wait_drain("rand");
    compare_stream("rand");
    spr_rd(2'd0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rand_status: got %h required 0", d); end
  endtask

  task automatic test_reset_mid_req();
    logic [31:0] d;
    int t = 0;
    ack_mode = 0;
    do_op(32'h77, 8);
    while (!store_byte_o && t < 20) begin @(negedge clk); t++; end
    checks++;
    if (t >= 20) begin errors++; $display("FAIL rreq_wait: store_byte_o never rose"); end
    @(negedge clk); rst_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({store_byte_o, vlx_addr_o, dat_o, stall_cpu_o} !== 66'h0) begin
      errors++;
      $display("FAIL rreq_outputs: store=%b addr=%h dat=%h stall=%b, required all zero",
               store_byte_o, vlx_addr_o, dat_o, stall_cpu_o);
    end
    @(negedge clk); rst_i = 1'b0;
    mbits.delete(); exp_q.delete(); maddr = 32'h0;
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL rreq_abandoned: %0d bytes stored, required 0", obs_q.size()); end
    obs_q.delete();
    spr_rd(2'd0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rreq_status: got %h required 0", d); end
    ack_mode = 1;
    do_op(32'h9A, 8);
    wait_drain("rreq");
    compare_stream("rreq");
  endtask

  initial begin
    rst_i = 1'b1; set_bit_op_i = 1'b0; bits_i = 32'h0; len_i = 5'd0;
    spr_cs_i = 1'b0; spr_write_i = 1'b0; spr_addr_i = 2'd0; spr_dat_i = 32'h0;
    test_reset();
    test_sequential();
    test_stuffing();
    test_flush_pad();
    test_flush_idle();
    test_addr_write_busy();
    test_backpressure();
    test_random();
    test_reset_mid_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
